input_memory_reader: RTL and testbench
======================================

# input_memory_reader

Fetches operand vectors from memory and streams them to the processing array: accepts one instruction (base address, vector count, row/column flag), reads each N-element vector from memory in PARALLEL_DATA_STREAMING_SIZE-element beats, and presents each assembled vector to the processor with a valid/ready handshake. It is the read-side counterpart of the output writer, sitting between the controller, memory and the array's A/B input ports, and reports completion to the controller through its own handshake.

## Interface
- INPUT_DATA_WIDTH, 8, element width in bits
- N, 4, processing array width (elements per vector)
- MEMORY_ADDRESS_BITS, 64, memory address width
- PARALLEL_DATA_STREAMING_SIZE (P), 4, elements per memory beat; must divide N
- MAX_MATRIX_LENGTH, 8, maximum vectors per instruction
- clk  in  1  clock; one clock domain, all logic on posedge
- reset  in  1  synchronous, active-high
- instruction_valid / instruction_ready  in / out  1  controller instruction handshake
- address_input  in  MEMORY_ADDRESS_BITS  base address of first element
- length_input  in  $clog2(MAX_MATRIX_LENGTH+1)  vector count, 0..MAX_MATRIX_LENGTH
- input_by_row_instruction  in  1  1 = row-wise feed, 0 = column-wise
- completed_valid / completed_ready  out / in  1  completion handshake to controller
- read_valid / read_ready  out / in  1  memory read request handshake
- read_address  out  MEMORY_ADDRESS_BITS  address of current beat
- read_data  in  INPUT_DATA_WIDTH x P  beat data, valid in the same cycle as read_valid && read_ready (zero-latency memory)
- data_valid / data_ready  out / in  1  processor stream handshake
- input_by_row  out  1  registered row/column flag for the processor
- data_streaming  out  INPUT_DATA_WIDTH x N  assembled vector

## Operation
- States: IDLE, FETCH, STREAM, DONE.
- IDLE: instruction_ready=1. On instruction_valid: latch address into addr_reg, length into remaining, flag into by_row_reg, clear beat counter. Go to FETCH if length!=0, else DONE.
- FETCH: read_valid=1, read_address=addr_reg. On read_valid&&read_ready: buffer[beat*P+i] <= read_data[i] for i in 0..P-1; addr_reg += P; beat += 1. On last beat (beat == N/P-1): beat <= 0, go to STREAM.
- STREAM: data_valid=1, data_streaming=buffer. On data_valid&&data_ready: remaining -= 1; go to DONE if remaining was 1, else FETCH.
- DONE: completed_valid=1. On completed_ready: go to IDLE.
- Addressing: element k of vector v read from base + v*N + k; addresses increment by P per beat, wrap modulo 2^MEMORY_ADDRESS_BITS with no error.
- input_by_row = by_row_reg; holds from acceptance until next instruction, cleared by reset.

## Timing
- Reset: state IDLE; instruction_ready=1; read_valid, data_valid, completed_valid, input_by_row = 0; read_address = 0; data_streaming = all 0; all counters and buffer cleared.
- Reset mid-operation discards the instruction and partial buffer; no completion is issued.
- Handshake rules: once asserted, read_valid/data_valid/completed_valid hold with stable address/data until accepted; no combinational path from ready inputs to valid outputs.
- Latency with ready held high: instruction accepted cycle 0; N/P FETCH cycles (1..N/P); first vector valid cycle N/P+1; per-vector throughput N/P+1 cycles; completed_valid in the cycle after the last STREAM handshake.
- Memory stall (read_ready=0) freezes beat counter and address; processor stall (data_ready=0) freezes buffer.
- instruction_valid is ignored outside IDLE. length_input > MAX_MATRIX_LENGTH is illegal (elaboration/sim assertion, no RTL handling).

## Structure
- Shared package (e.g. mm_engine_pkg): state enum type, counter-width localparams, elaboration assertion N % P == 0.
- Single module; the 4-state FSM plus an N-entry buffer needs no sub-module.

## Test plan
- N=4, P=2, address 0x100, length 2, readies high -> read addresses 0x100,0x102,0x104,0x106; two vectors out at cycles 3 and 6; completed_valid at cycle 7.
- read_ready low for 3 cycles mid-vector -> read_address held at 0x102, final vector contents unchanged vs. unstalled run.
- data_ready low for 5 cycles in STREAM -> data_valid and data_streaming held stable; no new reads issued.
- length 0 -> no read_valid; completed_valid the cycle after acceptance; completed_ready held low 4 cycles -> completed_valid stays 1, instruction_ready stays 0.
- reset asserted during second FETCH beat -> next cycle all outputs at reset values; new instruction at 0x200 reads from 0x200.
- address 0xFFFF_FFFF_FFFF_FFFE, N=4, P=2 -> second beat at 0x0000_0000_0000_0000; input_by_row matches latched flag throughout.

Source files
------------

// File: rtl/input_memory_reader_pkg.sv
// rtl/input_memory_reader_pkg.sv - shared types and sizing helpers for the input memory reader
package input_memory_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } reader_state_t;

    localparam int unsigned DEFAULT_N         = 4;
    localparam int unsigned DEFAULT_P         = 4;
    localparam int unsigned DEFAULT_MAX_LEN   = 8;

    // A counter for n distinct values needs at least one bit even when n is 1.
    function automatic int unsigned counter_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit splits_evenly(input int unsigned n, input int unsigned p);
        return (p != 0) && ((n % p) == 0);
    endfunction

endpackage

// File: rtl/input_memory_reader.sv
// rtl/input_memory_reader.sv - fetches N-element vectors from memory in P-element beats and streams them out
module input_memory_reader
    import input_memory_reader_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH             = 8,
    parameter int N                            = DEFAULT_N,
    parameter int MEMORY_ADDRESS_BITS          = 64,
    parameter int PARALLEL_DATA_STREAMING_SIZE = DEFAULT_P,
    parameter int MAX_MATRIX_LENGTH            = DEFAULT_MAX_LEN,
    localparam int P     = PARALLEL_DATA_STREAMING_SIZE,
    localparam int LEN_W = $clog2(MAX_MATRIX_LENGTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  instruction_valid,
    output logic                                  instruction_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]        address_input,
    input  logic [LEN_W-1:0]                      length_input,
    input  logic                                  input_by_row_instruction,
    output logic                                  completed_valid,
    input  logic                                  completed_ready,
    output logic                                  read_valid,
    input  logic                                  read_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]        read_address,
    input  logic [P-1:0][INPUT_DATA_WIDTH-1:0]    read_data,
    output logic                                  data_valid,
    input  logic                                  data_ready,
    output logic                                  input_by_row,
    output logic [N-1:0][INPUT_DATA_WIDTH-1:0]    data_streaming
);

    localparam int BEATS  = N / P;
    localparam int BEAT_W = counter_width(BEATS);

    if (!splits_evenly(N, P)) begin : g_bad_split
        $error("PARALLEL_DATA_STREAMING_SIZE must divide N");
    end

    reader_state_t                        state;
    logic [MEMORY_ADDRESS_BITS-1:0]       addr_reg;
    logic [LEN_W-1:0]                     remaining;
    logic [BEAT_W-1:0]                    beat;
    logic [N-1:0][INPUT_DATA_WIDTH-1:0]   buffer;

    assign read_address   = addr_reg;
    assign data_streaming = buffer;

    // All handshake outputs are registers so ready inputs never reach a valid combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            instruction_ready <= 1'b1;
            read_valid        <= 1'b0;
            data_valid        <= 1'b0;
            completed_valid   <= 1'b0;
            input_by_row      <= 1'b0;
            addr_reg          <= '0;
            remaining         <= '0;
            beat              <= '0;
            buffer            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instruction_valid) begin
                        addr_reg          <= address_input;
                        remaining         <= length_input;
                        input_by_row      <= input_by_row_instruction;
                        beat              <= '0;
                        instruction_ready <= 1'b0;
                        if (length_input != '0) begin
                            state      <= S_FETCH;
                            read_valid <= 1'b1;
                        end else begin
                            state           <= S_DONE;
                            completed_valid <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (read_ready) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat == BEAT_W'(b)) begin
                                for (int i = 0; i < P; i++) begin
                                    buffer[b*P+i] <= read_data[i];
                                end
                            end
                        end
                        addr_reg <= addr_reg + MEMORY_ADDRESS_BITS'(P);
                        if (beat == BEAT_W'(BEATS - 1)) begin
                            beat       <= '0;
                            state      <= S_STREAM;
                            read_valid <= 1'b0;
                            data_valid <= 1'b1;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        remaining  <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state           <= S_DONE;
                            completed_valid <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            read_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (completed_ready) begin
                        completed_valid   <= 1'b0;
                        instruction_ready <= 1'b1;
                        state             <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_length_legal: assert property (@(posedge clk) disable iff (reset)
        (instruction_valid && instruction_ready) |-> (length_input <= LEN_W'(MAX_MATRIX_LENGTH)));

endmodule

// File: tb/tb_input_memory_reader.sv
// tb/tb_input_memory_reader.sv - self-checking bench for input_memory_reader
module tb_input_memory_reader;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int P  = 2;
    localparam int AB = 64;
    localparam int ML = 8;
    localparam int LW = 4;

    typedef logic [N-1:0][W-1:0] vec_data_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                instruction_valid;
    logic                instruction_ready;
    logic [AB-1:0]       address_input;
    logic [LW-1:0]       length_input;
    logic                input_by_row_instruction;
    logic                completed_valid;
    logic                completed_ready;
    logic                read_valid;
    logic                read_ready;
    logic [AB-1:0]       read_address;
    logic [P-1:0][W-1:0] read_data;
    logic                data_valid;
    logic                data_ready;
    logic                input_by_row;
    vec_data_t           data_streaming;

    int vectors = 0;
    int errors  = 0;

    input_memory_reader #(
        .INPUT_DATA_WIDTH(W), .N(N), .MEMORY_ADDRESS_BITS(AB),
        .PARALLEL_DATA_STREAMING_SIZE(P), .MAX_MATRIX_LENGTH(ML)
    ) dut (
        .clk(clk), .reset(reset),
        .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
        .address_input(address_input), .length_input(length_input),
        .input_by_row_instruction(input_by_row_instruction),
        .completed_valid(completed_valid), .completed_ready(completed_ready),
        .read_valid(read_valid), .read_ready(read_ready),
        .read_address(read_address), .read_data(read_data),
        .data_valid(data_valid), .data_ready(data_ready),
        .input_by_row(input_by_row), .data_streaming(data_streaming)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_val(input logic [AB-1:0] a);
        return a[7:0] ^ {a[3:0], a[11:8]} ^ a[63:56];
    endfunction

    // Zero-latency memory: beat data is a pure function of the requested address.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < P; i++) read_data[i] = mem_val(read_address + AB'(i));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, 64'(instruction_ready), 64'd1);
        check({tag, "_read_valid"},  64'(read_valid), 64'd0);
        check({tag, "_data_valid"},  64'(data_valid), 64'd0);
        check({tag, "_completed"},   64'(completed_valid), 64'd0);
        check({tag, "_by_row"},      64'(input_by_row), 64'd0);
        check({tag, "_read_addr"},   read_address, 64'd0);
        check({tag, "_stream"},      64'(data_streaming), 64'd0);
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
    endfunction

    // Runs one instruction; rel counts cycles with the acceptance cycle as 0.
    task automatic run_txn(input logic [AB-1:0] base, input int len, input logic flag,
                           input int rr_pct, input int dr_pct, input int cr_pct,
                           input int rr_lo_a, input int rr_lo_b,
                           input int dr_lo_a, input int dr_lo_b, input int cr_lo_n,
                           input int exp_first, input int exp_done);
        logic [AB-1:0] raddr_q[$];
        vec_data_t     vec_q[$];
        vec_data_t     expv;
        int            rel, first_seen, done_seen, cr_left;
        bit            done;
        logic          pv_r, pr_r, pv_d, pr_d, pv_c, pr_c;
        logic [AB-1:0] pa;
        vec_data_t     pd;

        @(negedge clk);
        instruction_valid        = 1'b1;
        address_input            = base;
        length_input             = LW'(len);
        input_by_row_instruction = flag;
        read_ready = 1'b1; data_ready = 1'b1; completed_ready = pick(cr_pct);
        check("instr_ready_idle", 64'(instruction_ready), 64'd1);

        rel = 0; first_seen = 0; done_seen = 0; done = 0; cr_left = cr_lo_n;
        pv_r = 0; pr_r = 0; pv_d = 0; pr_d = 0; pv_c = 0; pr_c = 0; pa = '0; pd = '0;
        while (!done && rel < 600) begin
            @(negedge clk);
            rel++;
            address_input            = {$urandom, $urandom};
            length_input             = LW'($urandom_range(0, ML));
            input_by_row_instruction = ~flag;
            if (pv_r && !pr_r) begin
                check("read_hold_valid", 64'(read_valid), 64'd1);
                check("read_hold_addr", read_address, pa);
            end
            if (pv_d && !pr_d) begin
                check("data_hold_valid", 64'(data_valid), 64'd1);
                check("data_hold_value", 64'(data_streaming), 64'(pd));
            end
            if (pv_c && !pr_c) check("completed_hold", 64'(completed_valid), 64'd1);
            check("by_row_latched", 64'(input_by_row), 64'(flag));
            check("instr_ready_busy", 64'(instruction_ready), 64'd0);
            check("read_data_exclusive", 64'(read_valid & data_valid), 64'd0);
            if (data_valid && first_seen == 0) first_seen = rel;
            if (completed_valid && done_seen == 0) done_seen = rel;

            read_ready = (rel >= rr_lo_a && rel <= rr_lo_b) ? 1'b0 : pick(rr_pct);
            data_ready = (rel >= dr_lo_a && rel <= dr_lo_b) ? 1'b0 : pick(dr_pct);
            if (completed_valid && cr_left > 0) begin
                completed_ready = 1'b0;
                cr_left--;
            end else begin
                completed_ready = pick(cr_pct);
            end

            if (read_valid && read_ready) raddr_q.push_back(read_address);
            if (data_valid && data_ready) vec_q.push_back(data_streaming);
            if (completed_valid && completed_ready) begin
                done = 1;
                instruction_valid = 1'b0;
            end
            pv_r = read_valid; pr_r = read_ready; pa = read_address;
            pv_d = data_valid; pr_d = data_ready; pd = data_streaming;
            pv_c = completed_valid; pr_c = completed_ready;
        end
        instruction_valid = 1'b0;
        if (!done) check("timeout_completion", 64'd0, 64'd1);

        check("read_count", 64'(raddr_q.size()), 64'(len * N / P));
        foreach (raddr_q[j]) check("read_addr", raddr_q[j], base + AB'(j * P));
        check("vector_count", 64'(vec_q.size()), 64'(len));
        foreach (vec_q[v]) begin
            for (int k = 0; k < N; k++) expv[k] = mem_val(base + AB'(v * N + k));
            check("vector_data", 64'(vec_q[v]), 64'(expv));
        end
        if (exp_done > 0) begin
            check("first_valid_cycle", 64'(first_seen), 64'(exp_first));
            check("completed_cycle", 64'(done_seen), 64'(exp_done));
        end
        @(negedge clk);
        check("instr_ready_return", 64'(instruction_ready), 64'd1);
        check("completed_clear", 64'(completed_valid), 64'd0);
    endtask

    typedef struct {
        logic [AB-1:0] base;
        int            len;
        logic          flag;
        int            exp_first;
        int            exp_done;
    } vec_t;

    vec_t table_v[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        table_v[0] = '{64'h100,  2, 1'b0, 3, 7};
        table_v[1] = '{64'h40,   0, 1'b1, 0, 1};
        table_v[2] = '{64'h1000, 1, 1'b1, 3, 4};
        table_v[3] = '{64'h7F0,  3, 1'b0, 3, 10};
        table_v[4] = '{64'h0,    8, 1'b1, 3, 25};

        reset = 1'b1; instruction_valid = 1'b0; address_input = '0; length_input = '0;
        input_by_row_instruction = 1'b0; completed_ready = 1'b0; read_ready = 1'b0; data_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int t = 0; t < 5; t++)
            run_txn(table_v[t].base, table_v[t].len, table_v[t].flag, 100, 100, 100,
                    -1, -1, -1, -1, 0, table_v[t].exp_first, table_v[t].exp_done);

        // Memory stall on the second beat of the first vector.
        run_txn(64'h100, 2, 1'b0, 100, 100, 100, 2, 4, -1, -1, 0, 6, 10);
        // Processor stall for five cycles on the first vector.
        run_txn(64'h100, 2, 1'b1, 100, 100, 100, -1, -1, 3, 7, 0, 3, 12);
        // Zero-length instruction with the controller slow to take completion.
        run_txn(64'h500, 0, 1'b1, 100, 100, 100, -1, -1, -1, -1, 4, 0, 1);
        // Address wrap across 2^64.
        run_txn(64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b1, 100, 100, 100, -1, -1, -1, -1, 0, 3, 4);

        // Reset during the second fetch beat, then a fresh instruction.
        @(negedge clk);
        instruction_valid = 1'b1; address_input = 64'h300; length_input = 4'd2;
        input_by_row_instruction = 1'b1;
        read_ready = 1'b1; data_ready = 1'b1; completed_ready = 1'b1;
        @(negedge clk);
        instruction_valid = 1'b0;
        @(negedge clk);
        check("second_beat_addr", read_address, 64'h302);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        run_txn(64'h200, 1, 1'b0, 100, 100, 100, -1, -1, -1, -1, 0, 3, 4);

        for (int r = 0; r < 20; r++)
            run_txn({$urandom, $urandom}, $urandom_range(0, ML), 1'($urandom_range(1)),
                    $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                    -1, -1, -1, -1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
